// File: rtl/sram_arb_pkg.sv
// Shared constants, port ids and strobe expansion for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam int DEF_BITS   = 128;
    localparam int DEF_AW     = 6;
    localparam int DEF_STRB_W = DEF_BITS / 8;

    // Widest macro the strobe expander supports; callers truncate to their width.
    localparam int MAX_BITS   = 1024;
    localparam int MAX_STRB_W = MAX_BITS / 8;

    typedef enum logic {
        P_IFU = 1'b0,
        P_LSU = 1'b1
    } port_e;

    // Active-high byte strobes to the macro's active-low per-bit write mask.
    function automatic logic [MAX_BITS-1:0] strb_to_bwen(input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_BITS-1:0] mask;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            mask[i*8 +: 8] = {8{~strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sram_bw_arbiter_if.sv
// Request/response channel between one cache controller and the SRAM arbiter.
interface sram_bw_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int AW   = DEF_AW
) ();

    logic              valid;
    logic              ready;
    logic              we;
    logic [AW-1:0]     addr;
    logic [BITS-1:0]   wdata;
    logic [BITS/8-1:0] wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [BITS-1:0]   rdata;

    modport master (
        output valid, we, addr, wdata, wstrb, rsp_ready,
        input  ready, rsp_valid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata, wstrb, rsp_ready,
        output ready, rsp_valid, rdata
    );

endinterface

// File: rtl/sram_bw_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        // After a grant, favour the port that did not win.
        if (gnt != 2'b00) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_bw_arbiter.sv
// Shares one byte-maskable single-port SRAM between the I-side and D-side
// controllers, with one held, back-pressurable response slot.
module sram_bw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int DEPTH = 64,
    parameter int AW    = DEF_AW
) (
    input  logic              clk,
    input  logic              rst,
    sram_bw_arbiter_if.slave  r0,
    sram_bw_arbiter_if.slave  r1,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [BITS-1:0]   sram_bwen,
    output logic [AW-1:0]     sram_a,
    output logic [BITS-1:0]   sram_d,
    input  logic [BITS-1:0]   sram_q
);

    localparam int STRB_W = BITS / 8;

    if ((BITS % 8) != 0 || BITS > MAX_BITS) begin : g_bad_bits
        $error("BITS must be a multiple of 8 and no wider than MAX_BITS");
    end
    if (DEPTH != (1 << AW)) begin : g_bad_depth
        $error("DEPTH must equal 2**AW");
    end

    logic [1:0]        gnt;
    logic              gnt_any;
    logic              can_issue;
    logic              owner_ack;

    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [BITS-1:0]   sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;

    logic              full_q, full_d;
    port_e             owner_q, owner_d;
    logic              rd_q, rd_d;
    logic              fresh_q, fresh_d;
    logic [BITS-1:0]   data_q, data_d;
    logic [AW-1:0]     a_q;
    logic [BITS-1:0]   d_q;

    logic [BITS-1:0]   slot_rdata;
    logic              rsp_valid0, rsp_valid1;

    assign owner_ack = (owner_q == P_LSU) ? r1.rsp_ready : r0.rsp_ready;
    // A new access may start when the slot is free or is being drained this cycle.
    assign can_issue = !rst && (!full_q || owner_ack);

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({r1.valid, r0.valid}),
        .en  (can_issue),
        .gnt (gnt)
    );

    assign gnt_any  = |gnt;
    assign r0.ready = gnt[0];
    assign r1.ready = gnt[1];

    always_comb begin
        sel_we    = r0.we;
        sel_addr  = r0.addr;
        sel_wdata = r0.wdata;
        sel_wstrb = r0.wstrb;
        if (gnt[1]) begin
            sel_we    = r1.we;
            sel_addr  = r1.addr;
            sel_wdata = r1.wdata;
            sel_wstrb = r1.wstrb;
        end
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_bwen = '1;
        sram_a    = a_q;
        sram_d    = d_q;
        if (gnt_any) begin
            sram_cen = 1'b0;
            sram_wen = ~sel_we;
            sram_a   = sel_addr;
            sram_d   = sel_wdata;
            if (sel_we) begin
                sram_bwen = BITS'(strb_to_bwen(MAX_STRB_W'(sel_wstrb)));
            end
        end
    end

    always_comb begin
        full_d  = full_q;
        owner_d = owner_q;
        rd_d    = rd_q;
        fresh_d = 1'b0;
        data_d  = data_q;
        // sram_q is only meaningful in the cycle right after a read access.
        if (fresh_q) begin
            data_d = sram_q;
        end
        if (gnt_any) begin
            full_d  = 1'b1;
            owner_d = gnt[1] ? P_LSU : P_IFU;
            rd_d    = ~sel_we;
            fresh_d = ~sel_we;
        end else if (full_q && owner_ack) begin
            full_d = 1'b0;
        end
    end

    assign slot_rdata = (full_q && rd_q) ? (fresh_q ? sram_q : data_q) : '0;
    assign rsp_valid0 = !rst && full_q && (owner_q == P_IFU);
    assign rsp_valid1 = !rst && full_q && (owner_q == P_LSU);

    assign r0.rsp_valid = rsp_valid0;
    assign r1.rsp_valid = rsp_valid1;
    assign r0.rdata     = rsp_valid0 ? slot_rdata : '0;
    assign r1.rdata     = rsp_valid1 ? slot_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            owner_q <= P_IFU;
            rd_q    <= 1'b0;
            fresh_q <= 1'b0;
        end else begin
            full_q  <= full_d;
            owner_q <= owner_d;
            rd_q    <= rd_d;
            fresh_q <= fresh_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        if (gnt_any) begin
            a_q <= sel_addr;
            d_q <= sel_wdata;
        end
    end

endmodule

// File: tb/tb_sram_bw_arbiter.sv
// Randomized bench for sram_bw_arbiter against a transaction-level memory model.
module tb_sram_bw_arbiter;
    import sram_arb_pkg::*;

    localparam int BITS  = DEF_BITS;
    localparam int AW    = DEF_AW;
    localparam int SW    = DEF_STRB_W;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_bw_arbiter_if #(.BITS(BITS), .AW(AW)) r0_if ();
    sram_bw_arbiter_if #(.BITS(BITS), .AW(AW)) r1_if ();

    logic            sram_cen, sram_wen;
    logic [BITS-1:0] sram_bwen, sram_d, sram_q;
    logic [AW-1:0]   sram_a;

    sram_bw_arbiter #(.BITS(BITS), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0        (r0_if),
        .r1        (r1_if),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_bwen (sram_bwen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // Requester-side drive, indexed by port.
    logic            v  [2];
    logic            we [2];
    logic [AW-1:0]   ad [2];
    logic [BITS-1:0] wd [2];
    logic [SW-1:0]   ws [2];
    logic            rr [2];

    assign r0_if.valid = v[0];  assign r1_if.valid = v[1];
    assign r0_if.we    = we[0]; assign r1_if.we    = we[1];
    assign r0_if.addr  = ad[0]; assign r1_if.addr  = ad[1];
    assign r0_if.wdata = wd[0]; assign r1_if.wdata = wd[1];
    assign r0_if.wstrb = ws[0]; assign r1_if.wstrb = ws[1];
    assign r0_if.rsp_ready = rr[0];
    assign r1_if.rsp_ready = rr[1];

    logic            o_rdy  [2];
    logic            o_rv   [2];
    logic [BITS-1:0] o_rdat [2];
    assign o_rdy[0]  = r0_if.ready;     assign o_rdy[1]  = r1_if.ready;
    assign o_rv[0]   = r0_if.rsp_valid; assign o_rv[1]   = r1_if.rsp_valid;
    assign o_rdat[0] = r0_if.rdata;     assign o_rdat[1] = r1_if.rdata;

    // SRAM macro: masked write, registered Q, junk on Q whenever no read happened.
    logic [BITS-1:0] macro_mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_cen && sram_wen)
            sram_q <= macro_mem[sram_a];
        else
            sram_q <= {$urandom, $urandom, $urandom, $urandom};
        if (!sram_cen && !sram_wen)
            macro_mem[sram_a] <= (macro_mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
    end

    // Reference model: memory contents, round-robin favourite, one pending response.
    logic [BITS-1:0] ref_mem [DEPTH];
    int              ptr;
    bit              s_full;
    int              s_own;
    bit              s_rd;
    logic [BITS-1:0] s_data;
    int              g, last_g;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic step();
        bit              can, acc, exp_rv;
        logic [BITS-1:0] eb;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            can = !s_full || rr[s_own];
            if (can && v[0] && v[1]) g = ptr;
            else if (can && v[0])    g = 0;
            else if (can && v[1])    g = 1;
        end
        for (int p = 0; p < 2; p++) begin
            chk(p == 0 ? "r0_ready" : "r1_ready", BITS'(o_rdy[p]), BITS'(g == p));
            exp_rv = !rst && s_full && (s_own == p);
            chk(p == 0 ? "r0_rsp_valid" : "r1_rsp_valid", BITS'(o_rv[p]), BITS'(exp_rv));
            if (exp_rv)
                chk(p == 0 ? "r0_rdata" : "r1_rdata", o_rdat[p], s_rd ? s_data : '0);
        end
        chk("sram_cen", BITS'(sram_cen), BITS'(g < 0));
        eb = '1;
        if (g >= 0) begin
            chk("sram_wen", BITS'(sram_wen), BITS'(!we[g]));
            chk("sram_a", BITS'(sram_a), BITS'(ad[g]));
            chk("sram_d", sram_d, wd[g]);
            if (we[g])
                for (int b = 0; b < SW; b++)
                    if (ws[g][b]) eb[b*8 +: 8] = 8'h00;
        end else begin
            chk("sram_wen", BITS'(sram_wen), BITS'(1));
        end
        chk("sram_bwen", sram_bwen, eb);
        acc = !rst && s_full && rr[s_own];
        @(posedge clk);
        if (rst) begin
            s_full = 0;
            ptr    = 0;
        end else if (g >= 0) begin
            if (we[g]) begin
                for (int b = 0; b < SW; b++)
                    if (ws[g][b]) ref_mem[ad[g]][b*8 +: 8] = wd[g][b*8 +: 8];
                s_rd   = 0;
                s_data = '0;
            end else begin
                s_rd   = 1;
                s_data = ref_mem[ad[g]];
            end
            s_full = 1;
            s_own  = g;
            ptr    = 1 - g;
        end else if (acc) begin
            s_full = 0;
        end
        last_g = g;
        #1;
    endtask

    task automatic issue(input int p, input bit w, input int a, input logic [BITS-1:0] d,
                         input logic [SW-1:0] s, output int waited);
        v[p] = 1; we[p] = w; ad[p] = AW'(a); wd[p] = d; ws[p] = s;
        waited = 0;
        do begin
            step();
            waited++;
        end while (last_g != p && waited < 20);
        chk("issue_grant", BITS'(last_g), BITS'(p));
        v[p] = 0;
    endtask

    function automatic logic [BITS-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int n;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            macro_mem[i] = '0;
            ref_mem[i]   = '0;
        end
        for (int p = 0; p < 2; p++) begin
            v[p] = 0; we[p] = 0; ad[p] = '0; wd[p] = '0; ws[p] = '0; rr[p] = 1;
        end
        ptr = 0; s_full = 0; s_own = 0; s_rd = 0; s_data = '0; last_g = -1;

        rst = 1;
        v[0] = 1; v[1] = 1;
        step(); step();
        v[0] = 0; v[1] = 0;
        rst = 0;

        // Full write then read of the same word, back to back.
        issue(0, 1, 5, 128'h00112233445566778899AABBCCDDEEFF, '1, n);
        issue(0, 0, 5, '0, '0, n);
        chk("wr_rd_b2b", BITS'(n), BITS'(1));
        chk("rd5_data", o_rdat[0], 128'h00112233445566778899AABBCCDDEEFF);
        step();

        // Both ports requesting: grants alternate from port 0 after reset.
        rst = 1; step(); rst = 0;
        v[0] = 1; v[1] = 1; we[0] = 0; we[1] = 0; ad[0] = 6'd5; ad[1] = 6'd9;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("alt_gnt", BITS'(last_g), BITS'(i % 2));
        end
        v[0] = 0; v[1] = 0;
        step();

        // Partial write over a preloaded word.
        issue(1, 1, 3, {16{8'hAA}}, '1, n);
        issue(1, 1, 3, {16{8'h55}}, 16'h000F, n);
        issue(1, 0, 3, '0, '0, n);
        chk("partial_rd", o_rdat[1], {{12{8'hAA}}, {4{8'h55}}});
        step();

        // Response back-pressure blocks the other port; release grants it immediately.
        rr[1] = 0;
        issue(1, 0, 3, '0, '0, n);
        v[0] = 1; we[0] = 0; ad[0] = 6'd5;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("held_no_gnt", BITS'(last_g), BITS'(-1));
            chk("held_rdata", o_rdat[1], {{12{8'hAA}}, {4{8'h55}}});
        end
        rr[1] = 1;
        step();
        chk("release_gnt", BITS'(last_g), BITS'(0));
        v[0] = 0;
        step();

        // Reset while a read response is pending.
        issue(1, 0, 5, '0, '0, n);
        rst = 1; step(); rst = 0;
        v[0] = 1; v[1] = 1; we[0] = 0; we[1] = 0; ad[0] = 6'd3; ad[1] = 6'd5;
        step();
        chk("post_rst_gnt", BITS'(last_g), BITS'(0));
        chk("post_rst_no_r1_rsp", BITS'(o_rv[1]), BITS'(0));
        v[0] = 0; v[1] = 0;
        step(); step();

        // Zero-strobe write still issues and acks.
        issue(0, 1, 7, rnd_word(), '0, n);
        step();

        // Top address, write then read back to back.
        issue(0, 1, 63, rnd_word(), '1, n);
        issue(0, 0, 63, '0, '0, n);
        chk("wrap_b2b", BITS'(n), BITS'(1));
        step();

        // Random traffic with withdrawals, back-pressure and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (v[p] && last_g == p) v[p] = 0;
                if (!v[p]) begin
                    if ($urandom_range(2) == 0) begin
                        v[p]  = 1;
                        we[p] = $urandom_range(1) == 1;
                        case ($urandom_range(3))
                            0:       ad[p] = 6'd63;
                            1:       ad[p] = AW'($urandom_range(3));
                            default: ad[p] = AW'($urandom_range(DEPTH - 1));
                        endcase
                        wd[p] = rnd_word();
                        case ($urandom_range(3))
                            0:       ws[p] = '0;
                            1:       ws[p] = '1;
                            default: ws[p] = SW'($urandom);
                        endcase
                    end
                end else if ($urandom_range(15) == 0) begin
                    v[p] = 0;
                end
                rr[p] = $urandom_range(3) != 0;
            end
            rst = $urandom_range(299) == 0;
            step();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
